// File: rtl/nand2_pattern_checker.sv
// nand2_pattern_checker: drives 00,01,10,11 into a 2-input NAND under test,
// samples its output after a settle window and reports pass/fail results.
module nand2_pattern_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_out,
  output logic             dut_in0,
  output logic             dut_in1,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_vec
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  // counter counts down to zero, so S cycles of SETTLE need S-1 loaded
  localparam logic [3:0]       CNT_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           state_q;
  logic [1:0]       vec_q;
  logic [3:0]       cnt_q;
  logic             in0_q;
  logic             in1_q;
  logic             busy_q;
  logic             done_q;
  logic [ERR_W-1:0] err_q;
  logic             ffv_q;
  logic [1:0]       ffvec_q;

  logic             exp_d;
  logic             miss_d;
  logic [1:0]       vec_d;

  // expected NAND response and next vector for the current sample
  always_comb begin
    exp_d  = ~(vec_q[1] & vec_q[0]);
    miss_d = (dut_out != exp_d);
    vec_d  = vec_q + 2'd1;
  end

  // run sequencer with registered outputs and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 2'b00;
      cnt_q   <= 4'd0;
      in0_q   <= 1'b0;
      in1_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= SETTLE;
            vec_q   <= 2'b00;
            cnt_q   <= CNT_LOAD;
            in0_q   <= 1'b0;
            in1_q   <= 1'b0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= 2'b00;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_q == 4'd0) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        SAMPLE: begin
          if (miss_d) begin
            if (err_q != ERR_MAX) begin
              err_q <= err_q + 1'b1;
            end
            if (!ffv_q) begin
              ffv_q   <= 1'b1;
              ffvec_q <= vec_q;
            end
          end
          if (vec_q == 2'b11) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            in0_q   <= 1'b0;
            in1_q   <= 1'b0;
          end else begin
            state_q <= SETTLE;
            vec_q   <= vec_d;
            in0_q   <= vec_d[1];
            in1_q   <= vec_d[0];
            cnt_q   <= CNT_LOAD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dut_in0          = in0_q;
  assign dut_in1          = in1_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = done_q & (err_q == '0);
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_nand2_pattern_checker.sv
// tb_nand2_pattern_checker: directed runs with a good, stuck-1, stuck-0
// and toggling NAND model; ERR_W=3 and ERR_W=1 instances share stimulus.
module tb_nand2_pattern_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dut_out;
  logic [1:0] mode;
  logic       tog;

  logic       a_in0, a_in1, a_busy, a_done, a_pass, a_ffv;
  logic [2:0] a_err;
  logic [1:0] a_ffvec;
  logic       b_in0, b_in1, b_busy, b_done, b_pass, b_ffv;
  logic [0:0] b_err;
  logic [1:0] b_ffvec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // mode 0: good NAND, 1: stuck-1, 2: stuck-0, 3: toggling
  always_comb begin
    dut_out = 1'b0;
    case (mode)
      2'd0: dut_out = ~(a_in0 & a_in1);
      2'd1: dut_out = 1'b1;
      2'd2: dut_out = 1'b0;
      default: dut_out = tog;
    endcase
  end

  nand2_pattern_checker #(.SETTLE_CYCLES(2), .ERR_W(3)) u_a (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out),
    .dut_in0(a_in0), .dut_in1(a_in1), .busy(a_busy), .done(a_done),
    .pass(a_pass), .err_count(a_err), .first_fail_valid(a_ffv),
    .first_fail_vec(a_ffvec)
  );

  nand2_pattern_checker #(.SETTLE_CYCLES(2), .ERR_W(1)) u_b (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out),
    .dut_in0(b_in0), .dut_in1(b_in1), .busy(b_busy), .done(b_done),
    .pass(b_pass), .err_count(b_err), .first_fail_valid(b_ffv),
    .first_fail_vec(b_ffvec)
  );

  task automatic tick();
    @(posedge clk);
    tog = ~tog;
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_a"}, {a_in0, a_in1, a_busy, a_done, a_pass, a_ffv, a_ffvec},
        8'h00);
    chk({tag, "_aerr"}, {5'd0, a_err}, 8'h00);
    chk({tag, "_b"}, {b_in0, b_in1, b_busy, b_done, b_pass, b_ffv, b_ffvec},
        8'h00);
    chk({tag, "_berr"}, {7'd0, b_err}, 8'h00);
  endtask

  // accept start, then follow all 12 cycles checking the driven vector
  task automatic run_full(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        chk({tag, "_vec"}, {6'd0, a_in0, a_in1}, 8'(k));
        chk({tag, "_bvec"}, {6'd0, b_in0, b_in1}, 8'(k));
        chk({tag, "_busy"}, {6'd0, a_busy, a_done}, 8'b10);
        tick();
      end
    end
    chk({tag, "_end"}, {6'd0, a_busy, a_done}, 8'b01);
    chk({tag, "_endin"}, {6'd0, a_in0, a_in1}, 8'h00);
  endtask

  // accept start and wait out the run without per-cycle checks
  task automatic run_quiet();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
  endtask

  initial begin
    tog   = 1'b0;
    mode  = 2'd3;
    rst   = 1'b1;
    start = 1'b1;
    tick();
    tick();
    chk_reset("reset");
    rst   = 1'b0;
    start = 1'b0;
    mode  = 2'd0;
    tick();
    chk_reset("idle");

    // good NAND
    run_full("good");
    chk("good_pass", {5'd0, a_pass, a_ffv, b_pass}, 8'b101);
    chk("good_err", {5'd0, a_err}, 8'd0);

    // stuck at 1: only vector 11 mismatches
    mode = 2'd1;
    run_quiet();
    chk("s1_done", {6'd0, a_done, a_pass}, 8'b10);
    chk("s1_err", {5'd0, a_err}, 8'd1);
    chk("s1_ff", {5'd0, a_ffv, a_ffvec}, 8'b111);
    chk("s1_berr", {7'd0, b_err}, 8'd1);

    // stuck at 0: 00,01,10 mismatch; 1-bit counter saturates
    mode = 2'd2;
    run_quiet();
    chk("s0_err", {5'd0, a_err}, 8'd3);
    chk("s0_ff", {5'd0, a_ffv, a_ffvec}, 8'b100);
    chk("s0_berr", {7'd0, b_err}, 8'd1);
    chk("s0_bff", {5'd0, b_ffv, b_ffvec}, 8'b100);
    chk("s0_pass", {6'd0, a_pass, b_pass}, 8'b00);

    // restart from failing DONE with good DUT, start pulses mid-run
    mode  = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rs_clr", {3'd0, a_busy, a_done, a_ffv, a_ffvec}, 8'b10000);
    chk("rs_err", {5'd0, a_err}, 8'd0);
    repeat (3) tick();
    chk("rs_v01", {6'd0, a_in0, a_in1}, 8'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("rs_v10", {6'd0, a_in0, a_in1}, 8'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("rs_e11", {6'd0, a_busy, a_done}, 8'b10);
    tick();
    chk("rs_e12", {5'd0, a_busy, a_done, a_pass}, 8'b011);

    // start held high: back-to-back runs, done high one cycle
    start = 1'b1;
    tick();
    repeat (12) tick();
    chk("bb_done", {6'd0, a_busy, a_done}, 8'b01);
    tick();
    start = 1'b0;
    chk("bb_again", {6'd0, a_busy, a_done}, 8'b10);
    chk("bb_vec", {6'd0, a_in0, a_in1}, 8'd0);
    repeat (12) tick();
    chk("bb_end", {5'd0, a_busy, a_done, a_pass}, 8'b011);

    // reset while vector 10 settles, then a clean full run
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("mr_v10", {6'd0, a_in0, a_in1}, 8'd2);
    rst = 1'b1;
    tick();
    chk_reset("mr_rst");
    rst = 1'b0;
    tick();
    chk_reset("mr_idle");
    run_full("mr_run");
    chk("mr_pass", {5'd0, a_pass, a_ffv, b_pass}, 8'b101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
